// File: rtl/netrec_pkg.sv
// rtl/netrec_pkg.sv - shared types, header field layout and pin-count limits for the netlist record decoder.
package netrec_pkg;

  typedef enum logic [1:0] {
    ST_HDR  = 2'd0,
    ST_PIN  = 2'd1,
    ST_EMIT = 2'd2
  } state_t;

  localparam logic [2:0] MIN_PINS = 3'd2;
  localparam logic [2:0] MAX_PINS = 3'd4;

  localparam int HDR_TYPE_LSB = 3;
  localparam int HDR_TYPE_W   = 5;
  localparam int HDR_CNT_LSB  = 0;
  localparam int HDR_CNT_W    = 3;

  function automatic logic pin_cnt_ok(input logic [HDR_CNT_W-1:0] cnt);
    return (cnt >= MIN_PINS) && (cnt <= MAX_PINS);
  endfunction

endpackage

// File: rtl/netrec_fanout_table.sv
// rtl/netrec_fanout_table.sv - per-net saturating pin-count table, bumped once per emitted record.
module netrec_fanout_table
  import netrec_pkg::*;
#(
  parameter int NET_W    = 8,
  parameter int NUM_NETS = 30,
  parameter int FAN_W    = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clr,
  input  logic                upd,
  input  logic [4*NET_W-1:0]  nets,
  input  logic [2:0]          pin_cnt,
  input  logic [NET_W-1:0]    rd_addr,
  output logic [FAN_W-1:0]    rd_data
);

  localparam int SUM_W = FAN_W + 3;
  localparam logic [SUM_W-1:0] SAT = SUM_W'((1 << FAN_W) - 1);

  logic [FAN_W-1:0] tbl      [NUM_NETS];
  logic [FAN_W-1:0] tbl_next [NUM_NETS];

  // A net listed on several pins of one record collects one hit per pin.
  always_comb begin
    logic [SUM_W-1:0] sum;
    for (int i = 0; i < NUM_NETS; i++) begin
      sum = SUM_W'(tbl[i]);
      for (int k = 0; k < int'(MAX_PINS); k++) begin
        if ((3'(k) < pin_cnt) && (nets[k*NET_W +: NET_W] == NET_W'(i))) begin
          sum = sum + SUM_W'(1);
        end
      end
      tbl_next[i] = (sum > SAT) ? SAT[FAN_W-1:0] : sum[FAN_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_NETS; i++) tbl[i] <= '0;
    end else if (clr) begin
      for (int i = 0; i < NUM_NETS; i++) tbl[i] <= '0;
    end else if (upd) begin
      for (int i = 0; i < NUM_NETS; i++) tbl[i] <= tbl_next[i];
    end
  end

  // Addresses past the table fall through to zero.
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NUM_NETS; i++) begin
      if (rd_addr == NET_W'(i)) rd_data = tbl[i];
    end
  end

endmodule

// File: rtl/netlist_record_decoder.sv
// rtl/netlist_record_decoder.sv - parses header + 2..4 net-ID bytes into range-checked instance records.
// Optional per-net fanout table enabled by NETREC_FANOUT_EN.
module netlist_record_decoder
  import netrec_pkg::*;
#(
  parameter int NET_W    = 8,
  parameter int NUM_NETS = 30,
  parameter int INST_W   = 8,
  parameter int FAN_W    = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [7:0]          in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [INST_W-1:0]   out_inst_idx,
  output logic [4:0]          out_cell_type,
  output logic [2:0]          out_pin_cnt,
  output logic [4*NET_W-1:0]  out_nets,
  output logic                err_pin_cnt,
  output logic                err_net_range,
  output logic [7:0]          err_cnt
`ifdef NETREC_FANOUT_EN
  ,
  input  logic [NET_W-1:0]    fanout_rd_addr,
  output logic [FAN_W-1:0]    fanout_rd_data,
  input  logic                fanout_clr
`endif
);

  localparam logic [8:0] NUM_NETS_L = 9'(NUM_NETS);

  state_t                  state;
  logic [HDR_TYPE_W-1:0]   cell_type;
  logic [HDR_CNT_W-1:0]    pin_cnt;
  logic [4*NET_W-1:0]      nets;
  logic [1:0]              pin_ptr;
  logic                    range_flag;

  logic                    in_xfer;
  logic [HDR_CNT_W-1:0]    hdr_cnt;
  logic                    byte_bad;
  logic                    last_pin;
  logic                    hdr_bad;
  logic                    rng_bad;

  assign in_ready = (state != ST_EMIT);
  assign in_xfer  = in_valid && in_ready;
  assign hdr_cnt  = in_data[HDR_CNT_LSB +: HDR_CNT_W];
  assign byte_bad = ({1'b0, in_data} >= NUM_NETS_L);
  assign last_pin = ({1'b0, pin_ptr} == (pin_cnt - 3'd1));
  assign hdr_bad  = (state == ST_HDR) && in_xfer && !pin_cnt_ok(hdr_cnt);
  assign rng_bad  = (state == ST_PIN) && in_xfer && last_pin && (range_flag || byte_bad);

  assign out_cell_type = cell_type;
  assign out_pin_cnt   = pin_cnt;
  assign out_nets      = nets;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_HDR;
      cell_type     <= '0;
      pin_cnt       <= '0;
      nets          <= '0;
      pin_ptr       <= '0;
      range_flag    <= 1'b0;
      out_valid     <= 1'b0;
      out_inst_idx  <= '0;
      err_pin_cnt   <= 1'b0;
      err_net_range <= 1'b0;
      err_cnt       <= '0;
    end else begin
      err_pin_cnt   <= hdr_bad;
      err_net_range <= rng_bad;
      if ((hdr_bad || rng_bad) && (err_cnt != 8'hFF)) begin
        err_cnt <= err_cnt + 8'd1;
      end

      case (state)
        ST_HDR: begin
          if (in_xfer && pin_cnt_ok(hdr_cnt)) begin
            cell_type  <= in_data[HDR_TYPE_LSB +: HDR_TYPE_W];
            pin_cnt    <= hdr_cnt;
            nets       <= '0;
            pin_ptr    <= '0;
            range_flag <= 1'b0;
            state      <= ST_PIN;
          end
        end

        ST_PIN: begin
          if (in_xfer) begin
            nets[int'(pin_ptr)*NET_W +: NET_W] <= in_data[NET_W-1:0];
            pin_ptr    <= pin_ptr + 2'd1;
            range_flag <= range_flag || byte_bad;
            // The range verdict must include the byte arriving on this cycle.
            if (last_pin) begin
              if (range_flag || byte_bad) begin
                state <= ST_HDR;
              end else begin
                state     <= ST_EMIT;
                out_valid <= 1'b1;
              end
            end
          end
        end

        ST_EMIT: begin
          if (out_ready) begin
            out_valid    <= 1'b0;
            out_inst_idx <= out_inst_idx + INST_W'(1);
            state        <= ST_HDR;
          end
        end

        default: begin
          state     <= ST_HDR;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef NETREC_FANOUT_EN
  netrec_fanout_table #(
    .NET_W    (NET_W),
    .NUM_NETS (NUM_NETS),
    .FAN_W    (FAN_W)
  ) u_fanout (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (fanout_clr),
    .upd     ((state == ST_EMIT) && out_ready),
    .nets    (nets),
    .pin_cnt (pin_cnt),
    .rd_addr (fanout_rd_addr),
    .rd_data (fanout_rd_data)
  );
`else
  // FAN_W only sizes the fanout table; nothing to build without it.
  if (FAN_W < 1) begin : g_fan_w_unused
  end
`endif

endmodule

// File: tb/tb_netlist_record_decoder.sv
// tb/tb_netlist_record_decoder.sv - directed vector table plus corner sequences for netlist_record_decoder.
module tb_netlist_record_decoder;

  localparam int NET_W  = 8;
  localparam int INST_W = 8;
  localparam int FAN_W  = 4;
  localparam int NV     = 11;

  typedef struct {
    logic [7:0]  hdr;
    logic [31:0] pins;
    int          npins;
    bit          emit;
    logic [4:0]  typ;
    logic [2:0]  cnt;
    logic [31:0] nets;
    int          epin;
    int          erng;
  } vec_t;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic [7:0]         in_data = 8'h00;
  logic               out_valid;
  logic               out_ready = 1'b0;
  logic [INST_W-1:0]  out_inst_idx;
  logic [4:0]         out_cell_type;
  logic [2:0]         out_pin_cnt;
  logic [4*NET_W-1:0] out_nets;
  logic               err_pin_cnt;
  logic               err_net_range;
  logic [7:0]         err_cnt;
`ifdef NETREC_FANOUT_EN
  logic [NET_W-1:0]   fanout_rd_addr = '0;
  logic [FAN_W-1:0]   fanout_rd_data;
  logic               fanout_clr = 1'b0;
`endif

  int tests = 0;
  int fails = 0;
  int n_pin = 0;
  int n_rng = 0;
  vec_t vt [NV];

  netlist_record_decoder dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_data       (in_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_inst_idx  (out_inst_idx),
    .out_cell_type (out_cell_type),
    .out_pin_cnt   (out_pin_cnt),
    .out_nets      (out_nets),
    .err_pin_cnt   (err_pin_cnt),
    .err_net_range (err_net_range),
    .err_cnt       (err_cnt)
`ifdef NETREC_FANOUT_EN
    ,
    .fanout_rd_addr (fanout_rd_addr),
    .fanout_rd_data (fanout_rd_data),
    .fanout_clr     (fanout_clr)
`endif
  );

  always #5 clk = ~clk;

  always begin
    @(posedge clk);
    #1;
    if (err_pin_cnt) n_pin++;
    if (err_net_range) n_rng++;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running, required finish");
    $fatal(1, "timeout");
  end

  function automatic vec_t mk(input logic [7:0] h, input logic [31:0] pins, input int n,
                              input bit e, input logic [4:0] t, input logic [2:0] c,
                              input logic [31:0] nets, input int ep, input int er);
    vec_t v;
    v.hdr = h; v.pins = pins; v.npins = n; v.emit = e; v.typ = t; v.cnt = c;
    v.nets = nets; v.epin = ep; v.erng = er;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int waited;
    waited = 0;
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      tests++;
      fails++;
      $display("FAIL send_byte_timeout: in_ready 0, expected 1 within 50 cycles");
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send_rec(input logic [7:0] h, input logic [31:0] pins, input int n);
    send_byte(h);
    for (int p = 0; p < n; p++) send_byte(pins[p*8 +: 8]);
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

`ifdef NETREC_FANOUT_EN
  task automatic fan_chk(input int addr, input int exp);
    fanout_rd_addr = 8'(addr);
    #1;
    chk($sformatf("fanout[%0d]", addr), 32'(fanout_rd_data), 32'(exp));
  endtask
`endif

  initial begin
    int exp_idx;
    int exp_err;
    int bp;
    int br;

    vt[0]  = mk(8'h1B, 32'h001D0300, 3, 1'b1, 5'd3,  3'd3, 32'h001D0300, 0, 0);
    vt[1]  = mk(8'h05, 32'h00000000, 0, 1'b0, 5'd0,  3'd0, 32'h00000000, 1, 0);
    vt[2]  = mk(8'h0A, 32'h00000502, 2, 1'b1, 5'd1,  3'd2, 32'h00000502, 0, 0);
    vt[3]  = mk(8'h0C, 32'h06041E02, 4, 1'b0, 5'd0,  3'd0, 32'h00000000, 0, 1);
    vt[4]  = mk(8'hFC, 32'h0201001D, 4, 1'b1, 5'd31, 3'd4, 32'h0201001D, 0, 0);
    vt[5]  = mk(8'h00, 32'h00000000, 0, 1'b0, 5'd0,  3'd0, 32'h00000000, 1, 0);
    vt[6]  = mk(8'h07, 32'h00000000, 0, 1'b0, 5'd0,  3'd0, 32'h00000000, 1, 0);
    vt[7]  = mk(8'h12, 32'h000001FF, 2, 1'b0, 5'd0,  3'd0, 32'h00000000, 0, 1);
    vt[8]  = mk(8'h0A, 32'h00001E01, 2, 1'b0, 5'd0,  3'd0, 32'h00000000, 0, 1);
    vt[9]  = mk(8'h13, 32'h001D0807, 3, 1'b1, 5'd2,  3'd3, 32'h001D0807, 0, 0);
    vt[10] = mk(8'h01, 32'h00000000, 0, 1'b0, 5'd0,  3'd0, 32'h00000000, 1, 0);

    exp_idx = 0;
    exp_err = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst out_valid", 32'(out_valid), 32'd0);
    chk("rst in_ready", 32'(in_ready), 32'd1);
    chk("rst out_nets", out_nets, 32'd0);
    chk("rst cell_type", 32'(out_cell_type), 32'd0);
    chk("rst pin_cnt", 32'(out_pin_cnt), 32'd0);
    chk("rst inst_idx", 32'(out_inst_idx), 32'd0);
    chk("rst err_cnt", 32'(err_cnt), 32'd0);

    for (int v = 0; v < NV; v++) begin
      bp = n_pin;
      br = n_rng;
      send_rec(vt[v].hdr, vt[v].pins, vt[v].npins);
      chk($sformatf("v%0d out_valid", v), 32'(out_valid), 32'(vt[v].emit));
      if (vt[v].emit) begin
        chk($sformatf("v%0d in_ready", v), 32'(in_ready), 32'd0);
        chk($sformatf("v%0d cell_type", v), 32'(out_cell_type), 32'(vt[v].typ));
        chk($sformatf("v%0d pin_cnt", v), 32'(out_pin_cnt), 32'(vt[v].cnt));
        chk($sformatf("v%0d nets", v), out_nets, vt[v].nets);
        chk($sformatf("v%0d inst_idx", v), 32'(out_inst_idx), 32'(exp_idx));
        handshake();
        chk($sformatf("v%0d valid_drop", v), 32'(out_valid), 32'd0);
        exp_idx++;
      end
      @(negedge clk);
      exp_err += vt[v].epin + vt[v].erng;
      chk($sformatf("v%0d err_pin pulses", v), 32'(n_pin - bp), 32'(vt[v].epin));
      chk($sformatf("v%0d err_rng pulses", v), 32'(n_rng - br), 32'(vt[v].erng));
      chk($sformatf("v%0d err_cnt", v), 32'(err_cnt), 32'(exp_err));
    end

    // Backpressure: ten stalled cycles in EMIT with frozen outputs.
    send_rec(8'h1B, 32'h001D0300, 3);
    for (int c = 0; c < 10; c++) begin
      chk($sformatf("bp%0d out_valid", c), 32'(out_valid), 32'd1);
      chk($sformatf("bp%0d in_ready", c), 32'(in_ready), 32'd0);
      chk($sformatf("bp%0d nets", c), out_nets, 32'h001D0300);
      chk($sformatf("bp%0d inst_idx", c), 32'(out_inst_idx), 32'(exp_idx));
      @(negedge clk);
    end
    handshake();
    chk("bp release out_valid", 32'(out_valid), 32'd0);
    chk("bp release inst_idx", 32'(out_inst_idx), 32'(exp_idx + 1));
    exp_idx++;

    // out_ready held high: valid for exactly one cycle after the last pin byte.
    out_ready = 1'b1;
    send_rec(8'h0A, 32'h00000504, 2);
    chk("tp out_valid", 32'(out_valid), 32'd1);
    chk("tp nets", out_nets, 32'h00000504);
    @(negedge clk);
    chk("tp valid_drop", 32'(out_valid), 32'd0);
    chk("tp inst_idx", 32'(out_inst_idx), 32'(exp_idx + 1));
    out_ready = 1'b0;
    exp_idx++;

    // Error counter saturation.
    repeat (260) send_byte(8'h00);
    @(negedge clk);
    chk("err_cnt saturate", 32'(err_cnt), 32'd255);

    // Reset in the middle of a four-pin record.
    send_rec(8'h1C, 32'h00000403, 2);
    bp = n_pin;
    br = n_rng;
    rst_n = 1'b0;
    #1;
    chk("midrst out_valid", 32'(out_valid), 32'd0);
    chk("midrst in_ready", 32'(in_ready), 32'd1);
    chk("midrst nets", out_nets, 32'd0);
    chk("midrst cell_type", 32'(out_cell_type), 32'd0);
    chk("midrst pin_cnt", 32'(out_pin_cnt), 32'd0);
    chk("midrst inst_idx", 32'(out_inst_idx), 32'd0);
    chk("midrst err_cnt", 32'(err_cnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    send_rec(8'h0A, 32'h00000C0B, 2);
    chk("postrst out_valid", 32'(out_valid), 32'd1);
    chk("postrst inst_idx", 32'(out_inst_idx), 32'd0);
    chk("postrst nets", out_nets, 32'h00000C0B);
    chk("postrst cell_type", 32'(out_cell_type), 32'd1);
    handshake();
    @(negedge clk);
    chk("postrst no pulses", 32'((n_pin - bp) + (n_rng - br)), 32'd0);

`ifdef NETREC_FANOUT_EN
    send_rec(8'h0A, 32'h00000502, 2); handshake();
    send_rec(8'h0C, 32'h06040302, 4); handshake();
    send_rec(8'h0A, 32'h00000202, 2); handshake();
    fan_chk(2, 4);
    fan_chk(5, 1);
    fan_chk(3, 1);
    fan_chk(0, 0);
    fan_chk(200, 0);
    for (int r = 0; r < 10; r++) begin
      send_rec(8'h0A, 32'h00000707, 2);
      handshake();
    end
    fan_chk(7, 15);
    send_rec(8'h0A, 32'h00000909, 2);
    out_ready  = 1'b1;
    fanout_clr = 1'b1;
    @(negedge clk);
    out_ready  = 1'b0;
    fanout_clr = 1'b0;
    fan_chk(9, 0);
    fan_chk(2, 0);
    fan_chk(7, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
